// File: rtl/riscv_aes_wb_arb_pkg.sv
// Shared types and constants for the AES write-back arbiter and its picker.
// No logic of its own; latency not applicable.
// No flow control of its own; backpressure not applicable.
package riscv_aes_wb_arb_pkg;

  // The write-back unit always moves one full AES block.
  localparam int AES_DATA_W = 128;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_ACK    = 2'd2,
    ST_BUSY   = 2'd3
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int GNT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_aes_wb_rr_pick.sv
// Round-robin picker: first set bit of req scanning cyclically upward from ptr.
// Purely combinational, zero cycles.
// No backpressure; the caller decides whether the pick is consumed.
module riscv_aes_wb_rr_pick
  import riscv_aes_wb_arb_pkg::*;
#(
  parameter int    NREQ = 2,
  localparam int   GW   = GNT_W(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            any,
  output logic [NREQ-1:0] gnt,
  output logic [GW-1:0]   idx
);

  int cand;

  // Scan NREQ candidates starting at ptr; wrap uses a compare so that
  // non-power-of-two requester counts never alias onto a missing slot.
  always_comb begin
    any  = 1'b0;
    gnt  = '0;
    idx  = '0;
    cand = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand[GW-1:0]]) begin
        any                = 1'b1;
        gnt[cand[GW-1:0]]  = 1'b1;
        idx                = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/riscv_aes_wb_arb.sv
// Shares the AES write-back unit between NREQ producers, round-robin, one transfer at a time.
// Grant is combinational (req_ready same cycle), wb_start one cycle later, done on halt fall.
// Requesters hold valid until req_ready; no new grant while a transfer is in flight.
module riscv_aes_wb_arb
  import riscv_aes_wb_arb_pkg::*;
#(
  parameter int  NREQ   = 2,
  parameter int  ADDR_W = 32,
  parameter int  DATA_W = AES_DATA_W,  // fixed at 128; the write-back unit moves one block
  localparam int GW     = GNT_W(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          done,
  output logic                     wb_start,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_halt_en,
  output logic                     core_halt,
  output logic [GW-1:0]            gnt_id,
  output logic                     busy
);

  arb_state_e      state;
  logic [GW-1:0]   ptr;
  logic            pick_any;
  logic [NREQ-1:0] pick_gnt;
  logic [GW-1:0]   pick_idx;
  logic            grant;
  logic            finish;
  logic [GW-1:0]   ptr_nxt;
  logic [NREQ-1:0] gnt_oh;

  riscv_aes_wb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Accept and completion strobes are masked by reset so an aborted transfer never signals.
  assign grant     = (state == ST_IDLE) && pick_any && !rst;
  assign finish    = (state == ST_BUSY) && !wb_halt_en && !rst;
  assign req_ready = grant  ? pick_gnt : '0;
  assign done      = finish ? gnt_oh   : '0;
  assign wb_start  = (state == ST_LAUNCH);
  assign busy      = (state != ST_IDLE);
  assign core_halt = busy;
  assign ptr_nxt   = (gnt_id == GW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  // One-hot decode of the current owner for the done pulse.
  always_comb begin
    gnt_oh         = '0;
    gnt_oh[gnt_id] = 1'b1;
  end

  // Sequencer: latch the winner, launch, wait for halt rise, then halt fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt_id  <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            gnt_id  <= pick_idx;
            wb_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            wb_data <= req_data[pick_idx*DATA_W +: DATA_W];
            state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state <= ST_ACK;
        ST_ACK: begin
          if (wb_halt_en) state <= ST_BUSY;
        end
        ST_BUSY: begin
          // Pointer moves only when a transfer completes, never on grant.
          if (!wb_halt_en) begin
            ptr   <= ptr_nxt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
